multicycle_sequencer: RTL and testbench

Multi-cycle FSM that steps the 16-bit CPU datapath through fetch, decode, execute, memory and writeback. It arbitrates the single shared memory port between instruction fetch (address = PC) and data access (address = auxiliary register). Each per-step write enable decoded by Controller is gated so it fires only in its owning state. It also counts retired instructions, supports halt, and flags a sticky error on memory timeout.

---
 rtl/multicycle_sequencer_pkg.sv | 55 +++++
 rtl/multicycle_sequencer_mem_wait_timer.sv | 38 +++
 rtl/multicycle_sequencer.sv | 151 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared typedefs for the multi-cycle CPU control path.
//   opcode_t     : 5-bit opcode field from the instruction register; the
//                  encoding space is wider than the defined opcodes, so
//                  undefined values can reach the sequencer.
//   seq_state_t  : sequencer FSM states.
//   is_alu/is_mem: opcode class helpers used by the sequencer in EXEC.
package multicycle_sequencer_pkg;

  typedef enum logic [4:0] {
    ADD  = 5'd0,
    SUB  = 5'd1,
    AND  = 5'd2,
    OR   = 5'd3,
    XOR  = 5'd4,
    SLL  = 5'd5,
    SRL  = 5'd6,
    SRA  = 5'd7,
    ADDI = 5'd8,
    LUI  = 5'd9,
    ANDI = 5'd10,
    ORI  = 5'd11,
    XORI = 5'd12,
    LOA  = 5'd13,
    LW   = 5'd14,
    SW   = 5'd15,
    BEQ  = 5'd16,
    BNE  = 5'd17,
    JMP  = 5'd18,
    NOP  = 5'd19
  } opcode_t;

  typedef enum logic [3:0] {
    RST_IDLE,
    FETCH,
    FETCH_WAIT,
    DECODE,
    EXEC,
    MEM,
    MEM_WAIT,
    WB,
    HALT,
    ERROR
  } seq_state_t;

  // Opcodes whose result lands in the accumulator/feedback register.
  function automatic logic is_alu(opcode_t op);
    return op inside {[ADD:SRA], ADDI, LUI, ANDI, ORI, XORI, LOA};
  endfunction

  // Opcodes that need a data-side memory access.
  function automatic logic is_mem(opcode_t op);
    return op inside {LW, SW};
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Wait-cycle counter for the memory states of the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (held while outside memory states)
//   en         : one cycle spent waiting in a memory state
//   expired    : this is the last allowed waiting cycle (TIMEOUT cycles total)
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;
  logic         at_limit;

  // Saturating at TIMEOUT-1 keeps expired asserted if the FSM moves from one
  // wait state into the next on the final allowed cycle.
  assign at_limit = (cnt == W'(TIMEOUT - 1));
  assign expired  = en && at_limit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_limit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the 16-bit CPU datapath.
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> WB, arbitrates the single memory
// port between instruction fetch (PC) and data access (auxiliary register),
// gates the Controller write enables into their owning state, counts retired
// instructions, supports halt at an instruction boundary and traps into a
// sticky ERROR state on memory timeout.
//   op, ctrl_reg_we, ctrl_mem_we : decoded instruction / Controller strobes
//   halt_req                     : stop after the current instruction
//   mem_gnt, mem_rvalid          : memory handshake
//   mem_req, mem_addr_sel, mem_we: memory request (addr_sel 0 = PC, 1 = aux)
//   ir_we, mdr_we, acc_we, reg_we, pc_we : datapath register enables
//   halted, err, instr_cnt       : status
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  opcode_t          op,
  input  logic             ctrl_reg_we,
  input  logic             ctrl_mem_we,
  input  logic             halt_req,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             acc_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_t state, state_n;
  logic       in_wait;
  logic       expired;

  // The timer runs only in the four memory states; leaving them clears it,
  // so every entry to FETCH or MEM starts from zero.
  assign in_wait = (state inside {FETCH, FETCH_WAIT, MEM, MEM_WAIT});

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Retired-instruction counter: one increment per WB, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (state == WB) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Next-state logic. A handshake arriving on the last allowed cycle wins
  // over the timeout.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      RST_IDLE: state_n = FETCH;
      FETCH: begin
        if (mem_gnt && mem_rvalid) state_n = DECODE;
        else if (mem_gnt)          state_n = FETCH_WAIT;
        else if (expired)          state_n = ERROR;
      end
      FETCH_WAIT: begin
        if (mem_rvalid)   state_n = DECODE;
        else if (expired) state_n = ERROR;
      end
      DECODE: state_n = EXEC;
      EXEC:   state_n = is_mem(op) ? MEM : WB;
      MEM: begin
        // Writes never return rvalid, so a granted write completes at once.
        if (mem_gnt) state_n = (ctrl_mem_we || mem_rvalid) ? WB : MEM_WAIT;
        else if (expired) state_n = ERROR;
      end
      MEM_WAIT: begin
        if (mem_rvalid)   state_n = WB;
        else if (expired) state_n = ERROR;
      end
      WB:      state_n = halt_req ? HALT : FETCH;
      HALT:    state_n = halt_req ? HALT : FETCH;
      ERROR:   state_n = ERROR;
      default: state_n = RST_IDLE;
    endcase
  end

  // Output decode. Enables come from the registered state only (plus the
  // memory handshake and Controller strobes), so none can rise while rst_n
  // holds the FSM in RST_IDLE.
  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    acc_we       = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_gnt && mem_rvalid;
      end
      FETCH_WAIT: ir_we = mem_rvalid;
      EXEC:       acc_we = is_alu(op);
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = ctrl_mem_we;
        mdr_we       = mem_gnt && !ctrl_mem_we && mem_rvalid;
      end
      MEM_WAIT: begin
        // Keep the data address selected while the read completes.
        mem_addr_sel = 1'b1;
        mdr_we       = mem_rvalid;
      end
      WB: begin
        reg_we = ctrl_reg_we;
        pc_we  = 1'b1;
      end
      HALT:    halted = 1'b1;
      ERROR:   err    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer (TIMEOUT = 4, CNT_W = 4).
// The stimulus process pushes the hand-computed profile of each instruction;
// the monitor accumulates enable pulses from FETCH start to the pc_we pulse
// and compares against the popped entry.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  opcode_t    op = ADD;
  logic       ctrl_reg_we = 1'b0;
  logic       ctrl_mem_we = 1'b0;
  logic       halt_req = 1'b0;
  logic       mem_gnt, mem_rvalid;
  logic       mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, acc_we;
  logic       reg_we, pc_we, halted, err;
  logic [3:0] instr_cnt;

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .ctrl_reg_we(ctrl_reg_we),
    .ctrl_mem_we(ctrl_mem_we), .halt_req(halt_req), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
    .mem_we(mem_we), .ir_we(ir_we), .mdr_we(mdr_we), .acc_we(acc_we),
    .reg_we(reg_we), .pc_we(pc_we), .halted(halted), .err(err),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;      // cycles FETCH..WB inclusive
    int n_acc;
    int n_mdr;
    int n_memwe;
    int n_dmem;   // cycles with a data-side request
    int n_regwe;
    int cnt;      // instr_cnt seen during WB
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Memory responder: drives the handshake on the falling edge.
  int fetch_lat = 0, data_lat = 0;
  bit fetch_gnt_en = 1'b1, data_gnt_en = 1'b1;
  initial begin
    int pend, lat;
    pend = -1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = -1;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid = 1'b1;
          pend = -1;
        end
      end else if (mem_req && (mem_addr_sel ? data_gnt_en : fetch_gnt_en)) begin
        mem_gnt = 1'b1;
        if (!mem_we) begin
          lat = mem_addr_sel ? data_lat : fetch_lat;
          if (lat == 0) mem_rvalid = 1'b1;
          else pend = lat;
        end
      end
    end
  end

  // Monitor: samples 2 time units after the falling edge.
  initial begin
    bit   active;
    int   cyc, n_ir, n_acc, n_mdr, n_memwe, n_dmem, n_regwe;
    exp_t e;
    active = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (!active && mem_req && !mem_addr_sel) begin
        active = 1'b1;
        cyc = 0; n_ir = 0; n_acc = 0; n_mdr = 0; n_memwe = 0; n_dmem = 0; n_regwe = 0;
      end
      if (active) begin
        cyc++;
        n_ir    += int'(ir_we);
        n_acc   += int'(acc_we);
        n_mdr   += int'(mdr_we);
        n_memwe += int'(mem_we && mem_req && mem_addr_sel);
        n_dmem  += int'(mem_req && mem_addr_sel);
        n_regwe += int'(reg_we);
      end
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          check("retire_with_empty_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.lat);
          check("ir_we_pulses", n_ir, 1);
          check("acc_we_pulses", n_acc, e.n_acc);
          check("mdr_we_pulses", n_mdr, e.n_mdr);
          check("mem_we_pulses", n_memwe, e.n_memwe);
          check("data_req_cycles", n_dmem, e.n_dmem);
          check("reg_we_pulses", n_regwe, e.n_regwe);
          check("instr_cnt_at_wb", instr_cnt, e.cnt);
        end
        active = 1'b0;
      end
    end
  end

  // Issue one instruction and wait (bounded) until it retires.
  task automatic run_instr(input opcode_t o, input bit creg, input bit cmem,
                           input int flat, input int dlat, input bit hreq,
                           input int lat, input int acc, input int mdr,
                           input int memwe, input int dmem, input int regwe);
    exp_t e;
    bit   got;
    op = o;
    ctrl_reg_we = creg;
    ctrl_mem_we = cmem;
    fetch_lat = flat;
    data_lat = dlat;
    e = '{lat, acc, mdr, memwe, dmem, regwe, exp_cnt};
    exp_cnt = (exp_cnt + 1) % 16;
    exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (hreq && acc_we) halt_req = 1'b1;
      if (pc_we) begin
        got = 1'b1;
        break;
      end
    end
    check("retire_within_budget", got, 1);
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int nreq;

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1 check("reset_outputs",
             {mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, acc_we, reg_we,
              pc_we, halted, err, instr_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #3 check("rst_idle_outputs",
             {mem_req, mem_addr_sel, mem_we, ir_we, mdr_we, acc_we, reg_we,
              pc_we, halted, err}, 0);

    // ADD, zero-wait memory: 4-cycle instruction, count 1 five cycles after release.
    run_instr(ADD, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("instr_cnt_first", instr_cnt, 1);

    run_instr(LW,   1, 0, 0, 3, 0, 8, 0, 1, 0, 1, 1);  // 3 cycles in MEM_WAIT
    run_instr(SW,   0, 1, 0, 0, 0, 5, 0, 0, 1, 1, 0);  // write, no mdr_we
    run_instr(LW,   1, 0, 0, 0, 0, 5, 0, 1, 0, 1, 1);  // zero-wait load
    run_instr(ADDI, 1, 0, 2, 0, 0, 6, 1, 0, 0, 0, 1);  // 2-cycle fetch wait
    run_instr(BEQ,  0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    run_instr(opcode_t'(5'd25), 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1);  // undefined op
    run_instr(LOA,  1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1);

    // Halt requested during EXEC of SRA.
    run_instr(SRA, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 1);
    @(negedge clk);
    #3 check("halted_after_wb", {halted, pc_we, mem_req}, 3'b100);
    check("cnt_entering_halt", instr_cnt, 9);
    repeat (3) @(negedge clk);
    #3 check("halt_hold", {halted, instr_cnt}, {1'b1, 4'd9});
    halt_req = 1'b0;
    @(posedge clk);
    #1 check("fetch_after_halt", {halted, mem_req, mem_addr_sel}, 3'b010);

    // Counter wrap: six NOPs to 15, one more to 0.
    for (int i = 0; i < 6; i++) run_instr(NOP, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("instr_cnt_15", instr_cnt, 15);
    run_instr(NOP, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("instr_cnt_wrap", instr_cnt, 0);

    // Reset while MEM drives a write strobe.
    data_gnt_en = 1'b0;
    op = SW;
    ctrl_mem_we = 1'b1;
    ctrl_reg_we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    check("mem_write_strobe_seen", {seen, mem_req, mem_addr_sel}, 3'b111);
    rst_n = 1'b0;
    #1 check("async_reset_in_mem", {mem_we, mem_req, mem_addr_sel, instr_cnt}, 0);
    data_gnt_en = 1'b1;
    ctrl_mem_we = 1'b0;
    op = ADD;

    // Fetch timeout: no grant ever.
    fetch_gnt_en = 1'b0;
    reset_cycle();
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (err) break;
      if (mem_req) nreq++;
    end
    check("fetch_cycles_before_error", nreq, 4);
    check("err_after_fetch_timeout", err, 1);
    fetch_gnt_en = 1'b1;
    repeat (5) @(negedge clk);
    #3 check("err_sticky", {err, mem_req, halted, pc_we}, 4'b1000);
    rst_n = 1'b0;
    #1 check("err_cleared_by_reset", err, 0);

    // Data read one cycle past the timeout budget ends in ERROR, not WB.
    op = LW;
    ctrl_reg_we = 1'b1;
    fetch_lat = 0;
    data_lat = 4;
    reset_cycle();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #3;
      if (err) begin
        seen = 1'b1;
        break;
      end
    end
    check("mem_wait_timeout", {seen, instr_cnt}, {1'b1, 4'd0});

    @(negedge clk);
    #3 check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
